// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round helper functions.
// Imported by the round datapath and the block engine.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        FINAL,
        DONE
    } state_e;

    localparam logic [1:0] SEL_IV   = 2'd0;
    localparam logic [1:0] SEL_EXT  = 2'd1;
    localparam logic [1:0] SEL_PREV = 2'd2;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // IV packed so that element 0 is h0, matching the sha256/in ports.
    function automatic logic [7:0][31:0] iv_cv();
        logic [7:0][31:0] r;
        for (int i = 0; i < 8; i++) r[i] = IV[i];
        return r;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round. Ports: s_i/s_o working vars (0=a..7=h),
// p_i = h+K+W for this round, wk_i = K+W of the next round, p_o = next P.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [7:0][31:0] s_i,
    input  logic [31:0]      p_i,
    input  logic [31:0]      wk_i,
    output logic [7:0][31:0] s_o,
    output logic [31:0]      p_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1     = p_i + bsig1(s_i[4]) + ch(s_i[4], s_i[5], s_i[6]);
        t2     = bsig0(s_i[0]) + maj(s_i[0], s_i[1], s_i[2]);
        s_o[0] = t1 + t2;
        s_o[1] = s_i[0];
        s_o[2] = s_i[1];
        s_o[3] = s_i[2];
        s_o[4] = s_i[3] + t1;
        s_o[5] = s_i[4];
        s_o[6] = s_i[5];
        s_o[7] = s_i[6];
        // g becomes next round's h, so the next P folds it in now.
        p_o    = s_i[6] + wk_i;
    end

endmodule

// File: rtl/sha256_block_engine.sv
// SHA-256 block compressor, UNROLL rounds per clock, selectable chaining value.
// Ports: start/init_sel/message/in/abort in; busy/done/sha256 out.
module sha256_block_engine
    import sha256_pkg::*;
#(
    parameter int UNROLL     = 1,
    parameter int NUM_ROUNDS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        init_sel,
    input  logic [15:0][31:0] message,
    input  logic [7:0][31:0]  in,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [7:0][31:0]  sha256
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4) || NUM_ROUNDS != 64
        || (NUM_ROUNDS % UNROLL) != 0) begin : g_bad_param
        $error("sha256_block_engine: illegal UNROLL/NUM_ROUNDS");
    end

    state_e            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [15:0][31:0] win_q, win_d;
    logic [7:0][31:0]  st_q, st_d;
    logic [7:0][31:0]  hh_q, hh_d;
    logic [31:0]       p_q, p_d;
    logic [7:0][31:0]  dig_q, dig_d;
    logic [7:0][31:0]  prev_q, prev_d;
    logic [7:0][31:0]  cv;

    // Window holds W[t+1..t+16] during COMPUTE; ext appends the next UNROLL words.
    logic [15+UNROLL:0][31:0] ext;
    logic [7:0][31:0]         cs [UNROLL+1];
    logic [31:0]              cp [UNROLL+1];
    logic [31:0]              wk [UNROLL];
    logic [5:0]               kidx;

    always_comb begin
        ext = '0;
        ext[15:0] = win_q;
        for (int i = 16; i < 16 + UNROLL; i++) begin
            ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
        end
    end

    always_comb begin
        kidx = '0;
        for (int j = 0; j < UNROLL; j++) begin
            kidx  = cnt_q[5:0] + 6'(j + 1);
            wk[j] = ext[j] + K[kidx];
        end
    end

    assign cs[0] = st_q;
    assign cp[0] = p_q;

    for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
        sha256_round u_rnd (
            .s_i  (cs[j]),
            .p_i  (cp[j]),
            .wk_i (wk[j]),
            .s_o  (cs[j+1]),
            .p_o  (cp[j+1])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        st_d    = st_q;
        hh_d    = hh_q;
        p_d     = p_q;
        dig_d   = dig_q;
        prev_d  = prev_q;
        busy    = 1'b0;
        done    = 1'b0;
        cv      = iv_cv();
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (init_sel)
                        SEL_EXT:  cv = in;
                        SEL_PREV: cv = prev_q;
                        default:  cv = iv_cv();
                    endcase
                    win_d   = message;
                    st_d    = cv;
                    hh_d    = cv;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                p_d     = win_q[0] + K[0] + st_q[7];
                win_d   = ext[16:1];
                cnt_d   = '0;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                busy  = 1'b1;
                st_d  = cs[UNROLL];
                p_d   = cp[UNROLL];
                win_d = ext[15+UNROLL:UNROLL];
                cnt_d = cnt_q + 7'(UNROLL);
                if (cnt_d == 7'(NUM_ROUNDS)) state_d = FINAL;
            end
            FINAL: begin
                busy = 1'b1;
                for (int i = 0; i < 8; i++) dig_d[i] = hh_q[i] + st_q[i];
                prev_d  = dig_d;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort drops the job without touching the visible digest state.
        if (busy && abort) begin
            state_d = IDLE;
            dig_d   = dig_q;
            prev_d  = prev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            st_q    <= '0;
            hh_q    <= '0;
            p_q     <= '0;
            dig_q   <= '0;
            prev_q  <= iv_cv();
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            st_q    <= st_d;
            hh_q    <= hh_d;
            p_q     <= p_d;
            dig_q   <= dig_d;
            prev_q  <= prev_d;
        end
    end

    assign sha256 = dig_q;

endmodule

// File: doc/sha256_block_engine.md
Name: sha256_block_engine

Overview:
- Parametrised successor to the single-round SHA-256 compression block used in the bitcoin hashing datapath.
- Compresses one 512-bit message block per start using an internal K-constant ROM. Processes UNROLL rounds per clock.
- Supports three chaining-value sources (standard IV, external input, own previous digest), so multi-block messages can be hashed without an external feedback path.
- Adds abort and busy, which the previous block lacks.

Parameters:
- UNROLL, 1, rounds per clock; legal values 1, 2, 4 (elaboration error otherwise).
- NUM_ROUNDS, 64, fixed SHA-256 round count; must be divisible by UNROLL.

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  synchronous active-low reset
- start  input  1  begin compression; sampled only in IDLE
- init_sel  input  2  chaining source: 0 = standard IV, 1 = in[], 2 = previous digest register, 3 = reserved (treated as 0)
- message  input  16x32  block words w0..w15, sampled on the cycle start is accepted
- in  input  8x32  external chaining value, sampled on the cycle start is accepted
- abort  input  1  cancel the operation in progress
- busy  output  1  high from LOAD through FINAL inclusive
- done  output  1  one-cycle pulse in DONE
- sha256  output  8x32  digest; holds its value from DONE until the next FINAL

Behaviour:
- Reset, synchronous on reset_n = 0 at a clk edge:
  - state = IDLE; busy = 0; done = 0; sha256[0..7] = 0; round counter = 0.
  - Previous-digest register = standard IV (6a09e667 … 5be0cd19).
  - Reset overrides every other input, including mid-compression.
- States: IDLE -> LOAD -> COMPUTE -> FINAL -> DONE -> IDLE.
- IDLE:
  - When start = 1, capture message[] into the 16-word schedule window.
  - Capture the chaining value selected by init_sel into both h0..h7 and a..h; go to LOAD.
  - init_sel = 2 uses the digest register as it stood at the accept edge.
- LOAD: one cycle. Precompute P = w0 + K0 + h (the round-0 pipeline term); shift the window; counter = 0.
- COMPUTE: each cycle performs UNROLL chained rounds.
  - The window shifts by UNROLL words per cycle; new words come from the σ0/σ1 schedule recurrence.
  - Counter += UNROLL. After the cycle that completes round 63, go to FINAL.
  - COMPUTE lasts exactly 64/UNROLL cycles.
- FINAL:
  - hN <= hN + working var, mod 2^32.
  - sha256[] and the previous-digest register are loaded with the sums.
  - Go to DONE.
- DONE: done = 1 for exactly one cycle; return to IDLE.
  - start asserted during DONE is ignored; it must be re-presented in IDLE.
- Latency: start accept edge to done high = 64/UNROLL + 3 cycles (67 for UNROLL = 1, 35 for 2, 19 for 4).
- start while busy or in DONE: ignored; no queuing.
- abort:
  - In LOAD/COMPUTE/FINAL, abort wins over the normal transition: next state IDLE, busy drops next cycle.
  - done never pulses; sha256[] and the previous-digest register are unchanged.
  - abort in IDLE or DONE has no effect.
  - abort and start together in IDLE: start wins.
- Arithmetic: all additions are 32-bit modulo 2^32; rotate amounts are constants; no carries leave a word.
- message/in are not required to stay stable after the accept edge.

Decomposition:
- Package sha256_pkg:
  - K[0:63] constant array and the IV[0:7] constant.
  - State enum {IDLE, LOAD, COMPUTE, FINAL, DONE}.
  - init_sel encodings.
  - Pure functions: rotr, Σ0, Σ1, σ0, σ1, ch, maj.
- Sub-module sha256_round: purely combinational single round, taking a..h, P and the next P's w+K, and returning the updated a..h.
  - The engine instantiates UNROLL copies in a generate chain.

Test Plan:
- Empty message, padded block 80000000 followed by zeros, init_sel = 0, UNROLL = 1 -> done at cycle 67 after accept; sha256 = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- "abc" padded (61626380, zeros, 00000018), init_sel = 0, run with UNROLL = 1, 2, 4 -> ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done at 67 / 35 / 19 cycles respectively.
- 448-bit "abcdbcdecdefdefg…nopq": block 1 with init_sel = 0, then block 2 with init_sel = 2 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Repeat with block 2 using init_sel = 1 and in[] = block-1 digest -> identical result.
- abort asserted at COMPUTE round 30 after a prior "abc" result -> busy low next cycle, done never pulses, sha256 still ba7816bf…; a following start with init_sel = 2 chains from the "abc" digest.
- start pulsed again during COMPUTE and during DONE -> ignored; exactly one done pulse per accepted start.
- reset_n low for one edge mid-COMPUTE -> next cycle state IDLE, busy = 0, done = 0, sha256 = 0; init_sel = 2 afterwards behaves as standard IV ("abc" gives ba7816bf…).
